regfile_2r1w: RTL

- Parametrised successor to the single-port switch-driven register file.
- Provides 1 write port, 2 independent asynchronous read ports, optional hardwired-zero entry 0 and optional write-to-read bypass.
- Adds a sequential bulk-clear engine that zeroes every entry, one per cycle, with a busy/done handshake.
- Intended as the operand register file for the single-cycle/pipelined CPU datapath.

---
 rtl/regfile_2r1w.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with bulk-clear engine
// Entry 0 can be hardwired to zero; same-cycle write data can be forwarded to reads.
module regfile_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  wr_drop
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  idle;
  logic                  wr_zero;
  logic                  wr_en;

  assign idle    = (state == S_IDLE);
  assign wr_zero = (ZERO_REG != 0) && (waddr == '0);
  assign wr_en   = we && idle && !wr_zero;

  assign clr_busy = !idle;
  assign clr_done = (state == S_DONE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (clr_req) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt == ADDR_WIDTH'(DEPTH-1)) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_WIDTH'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      // Writes to the hardwired zero entry are dropped silently, never flagged.
      wr_drop <= we && !idle && !wr_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // wr_en already excludes the busy case, so the forward path is off during a clear.
  function automatic logic [DATA_WIDTH-1:0] rd_mux(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  fwd_en,
    input logic [ADDR_WIDTH-1:0] fwd_addr,
    input logic [DATA_WIDTH-1:0] fwd_data
  );
    if ((ZERO_REG != 0) && (addr == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && fwd_en && (addr == fwd_addr)) begin
      return fwd_data;
    end else begin
      return stored;
    end
  endfunction

  assign rdata_a = rd_mux(raddr_a, mem[raddr_a], wr_en, waddr, wdata);
  assign rdata_b = rd_mux(raddr_b, mem[raddr_b], wr_en, waddr, wdata);

endmodule
